// File: rtl/i_steer_n_pkg.sv
// Shared interconnect header-field definitions and helpers for the packet steer.
package i_steer_n_pkg;

    // Beat width of every interconnect stream.
    localparam int unsigned DATA_W = 64;

    // Header layout shared with other interconnect blocks.
    localparam int unsigned ADDR_LSB  = 0;
    localparam int unsigned ADDR_MSB  = 47;
    localparam int unsigned ROUTE_LSB = 48;
    localparam int unsigned ROUTE_MSB = 55;
    localparam int unsigned RSVD_LSB  = 56;
    localparam int unsigned RSVD_MSB  = 63;

    localparam int unsigned ROUTE_W = ROUTE_MSB - ROUTE_LSB + 1;
    localparam int unsigned ADDR_W  = ADDR_MSB - ADDR_LSB + 1;

    // Legal steer-field widths.
    localparam int unsigned ROUTE_BITS_MIN = 1;
    localparam int unsigned ROUTE_BITS_MAX = 3;

    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [ROUTE_W-1:0] route_t;

    // Drop the low nbits of the route field, zero-filling from the top, so the
    // next tree level sees its own selector in the low bits.
    function automatic data_t consume_route(input data_t d, input int unsigned nbits);
        data_t  r;
        route_t f;
        r = d;
        f = d[ROUTE_MSB:ROUTE_LSB];
        r[ROUTE_MSB:ROUTE_LSB] = f >> nbits;
        return r;
    endfunction

endpackage

// File: rtl/i_steer_fifo.sv
// Synchronous FIFO with registered full/empty flags; head entry is read combinationally.
module i_steer_fifo #(
    parameter int unsigned Width = 66,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    // No push while full, even if a pop happens this cycle: keeps ready registered.
    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    // Pointer, occupancy and flag next-state.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CntW'(Depth));
        empty_d = (count_d == '0);
    end

    // Control state with synchronous reset (flushes the buffer).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/i_steer_n.sv
// N-way packet steer: header tracking, route extraction/transform, buffered output demux.
module i_steer_n
    import i_steer_n_pkg::*;
#(
    parameter bit          CONSUME_ROUTE = 1'b0,
    parameter int unsigned HDR_BIT       = 31,
    parameter int unsigned ROUTE_BITS    = 1,
    parameter int unsigned DEPTH         = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             I_TVALID,
    output logic                             I_TREADY,
    input  logic [63:0]                      I_TDATA,
    input  logic                             I_TLAST,
    output logic [(2**ROUTE_BITS)-1:0]       O_TVALID,
    input  logic [(2**ROUTE_BITS)-1:0]       O_TREADY,
    output logic [64*(2**ROUTE_BITS)-1:0]    O_TDATA,
    output logic [(2**ROUTE_BITS)-1:0]       O_TLAST
);

    localparam int unsigned NPORTS  = 2 ** ROUTE_BITS;
    localparam int unsigned ENTRY_W = 1 + ROUTE_BITS + DATA_W;

    typedef logic [ROUTE_BITS-1:0] dir_t;

    logic               is_header_q, is_header_d;
    dir_t               routing_direction_q, routing_direction_d;
    dir_t               hdr_dir;
    dir_t               in_dir;
    data_t              in_data;
    logic               in_fire;

    logic               fifo_full;
    logic               fifo_empty;
    logic               head_pop;
    logic [ENTRY_W-1:0] head_entry;
    logic               head_last;
    dir_t               head_dir;
    data_t              head_data;

    assign I_TREADY = ~fifo_full & ~reset;
    assign in_fire  = I_TVALID & I_TREADY;

    // Steer field of a header beat: route bits on the response path, address bits otherwise.
    always_comb begin
        hdr_dir = '0;
        if (CONSUME_ROUTE) begin
            hdr_dir = I_TDATA[ROUTE_LSB +: ROUTE_BITS];
        end else begin
            hdr_dir = I_TDATA[HDR_BIT +: ROUTE_BITS];
        end
    end

    // Per-beat direction and data; only a response header beat is rewritten.
    always_comb begin
        in_dir  = is_header_q ? hdr_dir : routing_direction_q;
        in_data = I_TDATA;
        if (CONSUME_ROUTE && is_header_q) begin
            in_data = consume_route(I_TDATA, ROUTE_BITS);
        end
    end

    // Packet framing: the beat after a last beat is a header, and its direction sticks.
    always_comb begin
        is_header_d         = is_header_q;
        routing_direction_d = routing_direction_q;
        if (in_fire) begin
            is_header_d = I_TLAST;
            if (is_header_q) begin
                routing_direction_d = hdr_dir;
            end
        end
    end

    // Framing state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_header_q         <= 1'b1;
            routing_direction_q <= '0;
        end else begin
            is_header_q         <= is_header_d;
            routing_direction_q <= routing_direction_d;
        end
    end

    i_steer_fifo #(
        .Width (ENTRY_W),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (in_fire),
        .wdata_i ({I_TLAST, in_dir, in_data}),
        .pop_i   (head_pop),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_last, head_dir, head_data} = head_entry;

    // Demux: only the head's port sees valid, and only that port's ready pops it.
    always_comb begin
        O_TVALID           = '0;
        O_TVALID[head_dir] = ~fifo_empty;
        head_pop           = ~fifo_empty & O_TREADY[head_dir];
    end

    assign O_TDATA = {NPORTS{head_data}};
    assign O_TLAST = {NPORTS{head_last}};

endmodule

// File: tb/tb_i_steer_n.sv
// Directed bench: request-path and response-path instances, table vectors plus corner sequences.
module tb_i_steer_n;

    logic clk;

    // Request-path instance: HDR_BIT=30, 4 ports, DEPTH=4.
    logic         q_rst, q_ivalid, q_iready, q_ilast;
    logic [63:0]  q_idata;
    logic [3:0]   q_ovalid, q_oready, q_olast;
    logic [255:0] q_odata;

    // Response-path instance: 4 ports, DEPTH=2.
    logic         s_rst, s_ivalid, s_iready, s_ilast;
    logic [63:0]  s_idata;
    logic [3:0]   s_ovalid, s_oready, s_olast;
    logic [255:0] s_odata;

    int n_cmp = 0;
    int n_bad = 0;

    i_steer_n #(
        .CONSUME_ROUTE (1'b0),
        .HDR_BIT       (30),
        .ROUTE_BITS    (2),
        .DEPTH         (4)
    ) u_req (
        .clk      (clk),
        .reset    (q_rst),
        .I_TVALID (q_ivalid),
        .I_TREADY (q_iready),
        .I_TDATA  (q_idata),
        .I_TLAST  (q_ilast),
        .O_TVALID (q_ovalid),
        .O_TREADY (q_oready),
        .O_TDATA  (q_odata),
        .O_TLAST  (q_olast)
    );

    i_steer_n #(
        .CONSUME_ROUTE (1'b1),
        .HDR_BIT       (31),
        .ROUTE_BITS    (2),
        .DEPTH         (2)
    ) u_rsp (
        .clk      (clk),
        .reset    (s_rst),
        .I_TVALID (s_ivalid),
        .I_TREADY (s_iready),
        .I_TDATA  (s_idata),
        .I_TLAST  (s_ilast),
        .O_TVALID (s_ovalid),
        .O_TREADY (s_oready),
        .O_TDATA  (s_odata),
        .O_TLAST  (s_olast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rsp;
        logic [63:0] data;
        logic        last;
        int unsigned port;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] bp_beat(input int k);
        if (k == 0) return 64'h0000_0000_4000_0000;
        return 64'h0000_0000_0000_0100 + 64'(k);
    endfunction

    task automatic check_vec(input int idx);
        vec_t        v;
        logic [3:0]  vld;
        logic [63:0] d;
        logic        l;
        v = vecs[idx];
        if (v.rsp) begin
            vld = s_ovalid;
            d   = s_odata[v.port*64 +: 64];
            l   = s_olast[v.port];
        end else begin
            vld = q_ovalid;
            d   = q_odata[v.port*64 +: 64];
            l   = q_olast[v.port];
        end
        check($sformatf("vec%0d valid", idx), 64'(vld), 64'(4'b0001 << v.port));
        check($sformatf("vec%0d data", idx), d, v.exp_data);
        check($sformatf("vec%0d last", idx), 64'(l), 64'(v.last));
    endtask

    task automatic drive_vec(input int idx);
        q_ivalid = ~vecs[idx].rsp;
        s_ivalid = vecs[idx].rsp;
        q_idata  = vecs[idx].data;
        s_idata  = vecs[idx].data;
        q_ilast  = vecs[idx].last;
        s_ilast  = vecs[idx].last;
    endtask

    // Watchdog: every loop is bounded, this only guards against a stuck simulator.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int sent;
        int got_n;

        vecs[0]  = '{1'b0, 64'h0000_0000_8000_1234, 1'b0, 2, 64'h0000_0000_8000_1234};
        vecs[1]  = '{1'b0, 64'hDEAD_BEEF_C000_0001, 1'b0, 2, 64'hDEAD_BEEF_C000_0001};
        vecs[2]  = '{1'b0, 64'h1111_2222_3333_4444, 1'b1, 2, 64'h1111_2222_3333_4444};
        vecs[3]  = '{1'b0, 64'h0000_0000_0000_00A0, 1'b1, 0, 64'h0000_0000_0000_00A0};
        vecs[4]  = '{1'b0, 64'h0000_0000_4000_00A1, 1'b1, 1, 64'h0000_0000_4000_00A1};
        vecs[5]  = '{1'b0, 64'h0000_0000_3FFF_FFFF, 1'b1, 0, 64'h0000_0000_3FFF_FFFF};
        vecs[6]  = '{1'b0, 64'hFFFF_FFFF_7FFF_FFFF, 1'b1, 1, 64'hFFFF_FFFF_7FFF_FFFF};
        vecs[7]  = '{1'b0, 64'h0000_0000_C000_0000, 1'b0, 3, 64'h0000_0000_C000_0000};
        vecs[8]  = '{1'b0, 64'h0000_0000_0000_0000, 1'b1, 3, 64'h0000_0000_0000_0000};
        vecs[9]  = '{1'b1, 64'h01B7_2345_6789_ABCD, 1'b0, 3, 64'h012D_2345_6789_ABCD};
        vecs[10] = '{1'b1, 64'h0044_0000_0000_0001, 1'b1, 3, 64'h0044_0000_0000_0001};
        vecs[11] = '{1'b1, 64'hAAFC_0000_0000_0000, 1'b1, 0, 64'hAA3F_0000_0000_0000};
        vecs[12] = '{1'b1, 64'h0005_0000_0000_0055, 1'b1, 1, 64'h0001_0000_0000_0055};
        vecs[13] = '{1'b1, 64'h0006_FFFF_FFFF_FFFF, 1'b1, 2, 64'h0001_FFFF_FFFF_FFFF};

        // Reset state.
        q_rst = 1'b1; s_rst = 1'b1;
        q_ivalid = 1'b0; s_ivalid = 1'b0;
        q_idata = '0; s_idata = '0; q_ilast = 1'b0; s_ilast = 1'b0;
        q_oready = 4'b1111; s_oready = 4'b1111;
        repeat (2) @(negedge clk);
        check("reset req ovalid", 64'(q_ovalid), 64'h0);
        check("reset rsp ovalid", 64'(s_ovalid), 64'h0);
        check("reset req iready", 64'(q_iready), 64'h0);
        check("reset rsp iready", 64'(s_iready), 64'h0);
        q_rst = 1'b0; s_rst = 1'b0;
        #1;
        check("post-reset req iready", 64'(q_iready), 64'h1);
        check("post-reset rsp iready", 64'(s_iready), 64'h1);

        // Table: one beat per cycle, all ready, each beat seen one cycle later.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i > 0) check_vec(i - 1);
            drive_vec(i);
            #1;
            check($sformatf("vec%0d iready", i),
                  64'(vecs[i].rsp ? s_iready : q_iready), 64'h1);
        end
        @(negedge clk);
        check_vec(13);
        q_ivalid = 1'b0; s_ivalid = 1'b0;
        @(negedge clk);
        check("idle req ovalid", 64'(q_ovalid), 64'h0);
        check("idle rsp ovalid", 64'(s_ovalid), 64'h0);

        // Backpressure: 6-beat packet to stalled port 1 fills DEPTH=4.
        q_oready = 4'b1101;
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            q_ivalid = (sent < 6);
            q_idata  = bp_beat(sent);
            q_ilast  = (sent == 5);
            #1;
            if (q_ivalid && q_iready) sent++;
        end
        check("bp accepted before stall", 64'(sent), 64'd4);
        check("bp iready low when full", 64'(q_iready), 64'h0);
        check("bp ovalid port1", 64'(q_ovalid), 64'h2);
        check("bp head data", q_odata[127:64], bp_beat(0));

        got_n = 0;
        for (int c = 0; c < 30 && got_n < 6; c++) begin
            @(negedge clk);
            if (c == 0) q_oready = 4'b1111;
            q_ivalid = (sent < 6);
            q_idata  = bp_beat(sent);
            q_ilast  = (sent == 5);
            #1;
            if (c == 0) check("bp iready low on pop cycle", 64'(q_iready), 64'h0);
            if (c == 1) check("bp iready back after pop", 64'(q_iready), 64'h1);
            if (q_ovalid[1] && q_oready[1]) begin
                check($sformatf("bp drain%0d data", got_n), q_odata[127:64], bp_beat(got_n));
                check($sformatf("bp drain%0d last", got_n), 64'(q_olast[1]),
                      64'(got_n == 5));
                got_n++;
            end
            if (q_ivalid && q_iready) sent++;
        end
        check("bp beats drained", 64'(got_n), 64'd6);
        check("bp beats accepted", 64'(sent), 64'd6);
        q_ivalid = 1'b0;
        @(negedge clk);
        check("bp empty after drain", 64'(q_ovalid), 64'h0);

        // Head-of-line: A to stalled port 0, then B to ready port 1.
        q_oready = 4'b1110;
        q_ivalid = 1'b1; q_idata = 64'h0000_00AA_0000_0000; q_ilast = 1'b1;
        @(negedge clk);
        q_idata = 64'h0000_00BB_4000_0000;
        @(negedge clk);
        q_ivalid = 1'b0;
        repeat (2) @(negedge clk);
        check("hol A blocks B valid", 64'(q_ovalid), 64'h1);
        check("hol A data", q_odata[63:0], 64'h0000_00AA_0000_0000);
        q_oready = 4'b1111;
        @(negedge clk);
        check("hol B valid", 64'(q_ovalid), 64'h2);
        check("hol B data", q_odata[127:64], 64'h0000_00BB_4000_0000);
        @(negedge clk);
        check("hol empty", 64'(q_ovalid), 64'h0);

        // Reset after beat 2 of a 4-beat packet to port 2.
        q_oready = 4'b0000;
        q_ivalid = 1'b1; q_idata = 64'h0000_0000_8000_0001; q_ilast = 1'b0;
        @(negedge clk);
        q_idata = 64'h0000_0000_0000_0002;
        @(negedge clk);
        check("mid head on port2", 64'(q_ovalid), 64'h4);
        q_ivalid = 1'b0; q_rst = 1'b1;
        #1;
        check("mid iready in reset", 64'(q_iready), 64'h0);
        @(negedge clk);
        check("mid ovalid flushed", 64'(q_ovalid), 64'h0);
        q_rst = 1'b0;
        q_oready = 4'b1111;
        q_ivalid = 1'b1; q_idata = 64'h0000_0000_C000_0077; q_ilast = 1'b0;
        #1;
        check("mid iready after reset", 64'(q_iready), 64'h1);
        @(negedge clk);
        check("mid new header port3", 64'(q_ovalid), 64'h8);
        check("mid new header data", q_odata[255:192], 64'h0000_0000_C000_0077);
        q_idata = 64'h0000_0000_0000_0078; q_ilast = 1'b1;
        @(negedge clk);
        q_ivalid = 1'b0;
        check("mid body port3", 64'(q_ovalid), 64'h8);
        check("mid body data", q_odata[255:192], 64'h0000_0000_0000_0078);
        check("mid body last", 64'(q_olast[3]), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i_steer_n.md
# i_steer_n

Parametrised N-way packet steer for the interconnect. Each packet arrives on one input stream and leaves whole, header beat through last beat, on one of 2^ROUTE_BITS output ports. On the request path, the port is chosen from a field of the header address. On the response path, the port is chosen from the low bits of the header route field, and those bits are consumed. A DEPTH-entry buffer decouples the input from the outputs, so the block can sit in a fabric tree at any fan-out with tunable slack.

## Interface
- CONSUME_ROUTE, 0: 0 selects request path (steer on address); 1 selects response path (steer on route, then shift the route).
- HDR_BIT, 31: request path only; LSB of the address field used for steering; HDR_BIT+ROUTE_BITS ≤ 48.
- ROUTE_BITS, 1: steer field width; 1..3; NPORTS = 2^ROUTE_BITS.
- DEPTH, 2: buffer entries; power of two, ≥ 2.
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high.
- I_TVALID  in  1  input beat valid.
- I_TREADY  out  1  input beat accepted when high with I_TVALID.
- I_TDATA  in  64  input beat data.
- I_TLAST  in  1  last beat of packet.
- O_TVALID  out  NPORTS  per-port valid.
- O_TREADY  in  NPORTS  per-port ready.
- O_TDATA  out  64*NPORTS  port p on bits [64p+63:64p]; all ports carry the same head-entry data.
- O_TLAST  out  NPORTS  per-port last; all ports carry the same head-entry last.

## Operation
- Input is accepted when I_TVALID & I_TREADY. I_TREADY = !full & !reset.
- is_header is a register. It is set by reset. It is cleared on acceptance of a non-last beat. It is set on acceptance of a last beat.
- Header beat, direction dir:
  - Request path: I_TDATA[HDR_BIT+ROUTE_BITS-1:HDR_BIT].
  - Response path: I_TDATA[48+ROUTE_BITS-1:48].
- Header transform, response path only: bits [55:48] become {ROUTE_BITS zeros, old[55:48+ROUTE_BITS]}. All other bits pass unchanged. On the request path, data is unmodified.
- dir is latched into routing_direction on header acceptance. Non-header beats take routing_direction. Data is never altered on non-header beats.
- Buffer entry = {last, dir, data}. Entries are FIFO-ordered; there is no reordering.
- Head entry with port d = dir:
  - O_TVALID[d] = not empty; all other O_TVALID bits are 0.
  - The head pops when O_TREADY[d] is high with the head valid. O_TREADY of other ports is ignored.
- A single-beat packet (header with I_TLAST=1) leaves is_header set.
- A blocked output stalls all traffic once the buffer fills (head-of-line blocking; accepted by design).

## Timing
- Reset values:
  - O_TVALID = 0; buffer empty.
  - I_TREADY = 0 while reset is high; I_TREADY = 1 in the first cycle after reset.
  - is_header = 1; routing_direction = 0.
  - O_TDATA and O_TLAST are don't-care while O_TVALID = 0.
- Latency: a beat accepted at edge t is presented on O_* after edge t (registered output). Input-to-output is 1 cycle when the buffer is empty.
- Throughput: 1 beat/cycle sustained when the selected O_TREADY is held high.
- Full buffer: I_TREADY = 0 even if a pop occurs in the same cycle. There is no pass-through when full, so the ready path stays registered. It reasserts the cycle after the pop.
- Simultaneous push and pop when not full: both take effect; count is unchanged.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Once O_TVALID is asserted, O_TVALID, O_TDATA and O_TLAST are held stable until the pop.
- Reset mid-packet: the buffer is flushed and is_header is set. The next accepted beat is treated as a header.

## Structure
- Shared package or header holds:
  - ROUTE_LSB = 48, ROUTE_MSB = 55.
  - Header-field constants, shared with other interconnect blocks.
- Sub-module i_steer_fifo: synchronous FIFO of width 65+ROUTE_BITS and depth DEPTH, with registered full/empty.
- The top level holds only header tracking, route extraction/transform and output demux.

## Test plan
- Request path, ROUTE_BITS=2, HDR_BIT=30: 3-beat packet, header address bit field [31:30]=2'b10 → all 3 beats exit port 2 only, data bit-exact, TLAST on beat 3.
- Response path, ROUTE_BITS=2: header [55:48]=0xB7 → exits port 3; output header [55:48]=0x2D; other bits unchanged.
- Back-to-back single-beat packets to ports 0,1,0,1 with all O_TREADY=1 → 1 beat/cycle, correct ports, 1-cycle latency.
- Backpressure, DEPTH=4: O_TREADY[1]=0 while a 6-beat packet for port 1 streams in → I_TREADY drops after 4 beats. Raising O_TREADY[1] drains in order, and I_TREADY returns 1 cycle after the first pop.
- Head-of-line: packet A to port 0 (stalled), packet B to port 1 (ready) → B is not emitted until A drains.
- Reset asserted after beat 2 of a 4-beat packet → O_TVALID=0 next cycle. A subsequent beat with address field selecting port 3 is treated as a header and routed to port 3.
